savomax_sync_gen: RTL and testbench
===================================

// Module: savomax_sync_gen
// PURPOSE
//  Generates PAL or NTSC test sync timing (hsync, vsync, csync) from one system clock.
//  It is the transmit-side counterpart of the VSYNC-period format detector.
//  Drives bench/board stimulus so the detector classifies PAL (field > 18 ms) vs NTSC.
//  Progressive by default; interlaced fields are optional.
// PARAMETERS
//  CLK_FREQ      250_000  input clock frequency, Hz
//  HSYNC_CLKS    1        hsync low width, clocks (1 <= HSYNC_CLKS < line length)
//  VSYNC_LINES   3        vsync low width, lines (1..9)
//  Derived localparams:
//    LINE_PAL  = CLK_FREQ/15625 (=16)
//    LINE_NTSC = (CLK_FREQ*1001)/15_750_000 (=15)
//    LINES_PAL = 312, LINES_NTSC = 262
// PORTS
//  clk_in          in   1  system clock
//  rst_n_in        in   1  asynchronous active-low reset
//  enable_in       in   1  1 = generate, 0 = idle
//  format_sel_in   in   1  1 = PAL, 0 = NTSC
//  hsync_out       out  1  horizontal sync, active low
//  vsync_out       out  1  vertical sync, active low
//  csync_out       out  1  composite sync, active low
//  field_start_out out  1  1-clk pulse, coincident with vsync_out falling edge
//  format_out      out  3  active format: 3'b000 unknown/idle, 3'b010 NTSC, 3'b100 PAL
//  field_odd_out   out  1  1 during the odd (long) field; interlace only
// BEHAVIOUR
//  Reset (async, rst_n_in=0):
//    state=IDLE, counters 0
//    hsync/vsync/csync_out=1, field_start_out=0, format_out=000, field_odd_out=0
//  One clock (clk_in) and one reset (rst_n_in); reset is asynchronous and active-low.
//  FSM:
//    IDLE -> ARM when enable_in=1
//    ARM  -> RUN after exactly one cycle; ARM latches format_sel_in into fmt, zeroes h_cnt/l_cnt
//    RUN  -> IDLE in the cycle enable_in=0 is sampled; outputs return to reset values next edge
//  Counters (RUN only):
//    h_cnt[15:0] counts 0..LINE-1; at LINE-1 it wraps to 0 and l_cnt increments
//    l_cnt[9:0] counts 0..LINES-1; at LINES-1 it wraps to 0 = field boundary
//  Field boundary:
//    format_sel_in is re-sampled here only; mid-field changes are ignored until the boundary
//    The new format's LINE/LINES apply from line 0 of the new field
//  Outputs are registered, 1-cycle latency after counter state (h,l):
//    hsync_out  = ~(h < HSYNC_CLKS)
//    vsync_out  = ~(l < VSYNC_LINES)
//    csync_out  = hsync_out ^ ~vsync_out (hsync inverted during vsync, serration style)
//    field_start_out = 1 for (h,l) = (0,0)
//    format_out = fmt code while RUN, else 000
//  First vsync_out falling edge: 2 clocks after enable_in is sampled high (ARM + 1 latency)
//  Field periods in clocks:
//    PAL  = 312*16 = 4992 (19.97 ms) -> detector reports PAL
//    NTSC = 262*15 = 3930 (15.72 ms) -> detector reports NTSC
//  enable_in toggling 0->1 always restarts at line 0; no partial field is resumed
//  Reset asserted mid-field: outputs go high immediately, without waiting for a clock edge
//  Widths: all compares are unsigned; CLK_FREQ*1001 is evaluated as a 64-bit constant
// CONFIGURATION
//  SAVOMAX_INTERLACE_EN defined:
//    Fields alternate short/long: PAL 312/313 lines, NTSC 262/263 lines
//    field_odd_out toggles at each field boundary and is 1 during the long field
//    The first field after ARM is short
//  SAVOMAX_INTERLACE_EN undefined:
//    Fixed 312/262 lines; field_odd_out tied 0
// TESTING
//  1. Reset, enable=1, sel=1 -> vsync falls at cycle 2; fall-to-fall spacing 4992; format_out=100
//  2. sel=0 -> vsync spacing 3930; hsync period 15 with 1-clk low; format_out=010
//  3. sel 1->0 at line 100 -> current field still 4992 clks; next spacing 3930; no glitch pulse
//  4. rst_n_in=0 mid-vsync (line 1) -> vsync/csync/hsync_out=1 at once; restart yields vsync at cycle 2
//  5. enable_in=0 for 1 clk at line 200 -> outputs idle next edge; re-enable gives a clean field from line 0
//  6. SAVOMAX_INTERLACE_EN, PAL -> spacings alternate 4992/5008; field_odd_out=1 in 5008 field; detector=PAL

Source files
------------

// File: rtl/savomax_sync_gen.sv
// -----------------------------------------------------------------------------
// savomax_sync_gen
//
// Generates PAL or NTSC test sync timing (hsync, vsync, csync) from a single
// system clock. It is the transmit-side counterpart of the VSYNC-period format
// detector: a PAL field lasts longer than 18 ms and an NTSC field is shorter,
// so the detector can classify the stream from the vsync period alone.
//
// Optional feature, selected with the macro SAVOMAX_INTERLACE_EN:
//   defined   - fields alternate short/long (PAL 312/313, NTSC 262/263 lines),
//               and field_odd_out is 1 during the long field. The first field
//               after ARM is short.
//   undefined - progressive: fixed 312/262 lines, and field_odd_out is tied 0.
//
// Ports
//   clk_in          in   1  system clock
//   rst_n_in        in   1  asynchronous active-low reset
//   enable_in       in   1  level: 1 = generate, 0 = idle
//   format_sel_in   in   1  1 = PAL, 0 = NTSC (sampled at ARM and at field
//                           boundaries only)
//   hsync_out       out  1  horizontal sync, active low
//   vsync_out       out  1  vertical sync, active low
//   csync_out       out  1  composite sync, active low (hsync inverted in vsync)
//   field_start_out out  1  1-clk pulse coincident with the vsync_out falling edge
//   format_out      out  3  3'b000 idle, 3'b010 NTSC, 3'b100 PAL
//   field_odd_out   out  1  1 during the long field (interlace build only)
//   fsm_state_out   out  2  current FSM state (0 IDLE, 1 ARM, 2 RUN), debug only
//
// enable_in is a plain level with no handshake: RUN continues while it is high,
// and the FSM drops to IDLE in the cycle a low level is sampled.
// -----------------------------------------------------------------------------
module savomax_sync_gen #(
    parameter int unsigned CLK_FREQ    = 250_000,
    parameter int unsigned HSYNC_CLKS  = 1,
    parameter int unsigned VSYNC_LINES = 3
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       enable_in,
    input  logic       format_sel_in,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       csync_out,
    output logic       field_start_out,
    output logic [2:0] format_out,
    output logic       field_odd_out,
    output logic [1:0] fsm_state_out
);

    // Line lengths in clocks. The NTSC product is taken at 64 bits so large
    // clock frequencies do not overflow before the divide.
    localparam logic [63:0] NTSC_NUM   = 64'(CLK_FREQ) * 64'd1001;
    localparam logic [15:0] LINE_PAL   = 16'(CLK_FREQ / 15625);
    localparam logic [15:0] LINE_NTSC  = 16'(NTSC_NUM / 64'd15_750_000);
    localparam logic [9:0]  LINES_PAL  = 10'd312;
    localparam logic [9:0]  LINES_NTSC = 10'd262;
    localparam logic [15:0] HSYNC_W    = 16'(HSYNC_CLKS);
    localparam logic [9:0]  VSYNC_W    = 10'(VSYNC_LINES);

`ifdef SAVOMAX_INTERLACE_EN
    localparam bit INTERLACE = 1'b1;
`else
    localparam bit INTERLACE = 1'b0;
`endif

    localparam logic [2:0] FMT_IDLE = 3'b000;
    localparam logic [2:0] FMT_NTSC = 3'b010;
    localparam logic [2:0] FMT_PAL  = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t      state;
    logic        fmt;         // 1 = PAL for the current field
    logic        long_field;  // current field carries the extra line
    logic [15:0] h_cnt;
    logic [9:0]  l_cnt;

    logic [15:0] line_len;
    logic [9:0]  field_lines;
    logic        h_last;
    logic        l_last;
    logic        hs_n;
    logic        vs_n;
    logic        cs_n;

    always_comb begin
        line_len    = fmt ? LINE_PAL : LINE_NTSC;
        field_lines = (fmt ? LINES_PAL : LINES_NTSC) + {9'd0, long_field};
        h_last      = (h_cnt == line_len - 16'd1);
        l_last      = (l_cnt == field_lines - 10'd1);
        hs_n        = ~(h_cnt < HSYNC_W);
        vs_n        = ~(l_cnt < VSYNC_W);
        // Serration: hsync is inverted for the duration of vsync.
        cs_n        = hs_n ^ ~vs_n;
    end

    assign fsm_state_out = state;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= IDLE;
            fmt             <= 1'b0;
            long_field      <= 1'b0;
            h_cnt           <= 16'd0;
            l_cnt           <= 10'd0;
            hsync_out       <= 1'b1;
            vsync_out       <= 1'b1;
            csync_out       <= 1'b1;
            field_start_out <= 1'b0;
            format_out      <= FMT_IDLE;
            field_odd_out   <= 1'b0;
        end else begin
            // Idle output values unless RUN overrides them below.
            hsync_out       <= 1'b1;
            vsync_out       <= 1'b1;
            csync_out       <= 1'b1;
            field_start_out <= 1'b0;
            format_out      <= FMT_IDLE;
            field_odd_out   <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable_in) state <= ARM;
                end

                ARM: begin
                    // Every start is a fresh short field at line 0.
                    fmt        <= format_sel_in;
                    long_field <= 1'b0;
                    h_cnt      <= 16'd0;
                    l_cnt      <= 10'd0;
                    state      <= RUN;
                end

                RUN: begin
                    if (!enable_in) begin
                        state <= IDLE;
                    end else begin
                        hsync_out       <= hs_n;
                        vsync_out       <= vs_n;
                        csync_out       <= cs_n;
                        field_start_out <= (h_cnt == 16'd0) && (l_cnt == 10'd0);
                        format_out      <= fmt ? FMT_PAL : FMT_NTSC;
                        field_odd_out   <= INTERLACE & long_field;

                        if (h_last) begin
                            h_cnt <= 16'd0;
                            if (l_last) begin
                                // Field boundary: the only point where the
                                // format selection is taken, so a field is
                                // never cut short or stretched mid-way.
                                l_cnt      <= 10'd0;
                                fmt        <= format_sel_in;
                                long_field <= INTERLACE & ~long_field;
                            end else begin
                                l_cnt <= l_cnt + 10'd1;
                            end
                        end else begin
                            h_cnt <= h_cnt + 16'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_savomax_sync_gen.sv
module tb_savomax_sync_gen;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       enable_in = 1'b0;
    logic       format_sel_in = 1'b0;
    logic       hsync_out;
    logic       vsync_out;
    logic       csync_out;
    logic       field_start_out;
    logic [2:0] format_out;
    logic       field_odd_out;
    logic [1:0] fsm_state_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    localparam int PAL_F1 = 312 * 16;   // 4992
    localparam int NTSC_F1 = 262 * 15;  // 3930
`ifdef SAVOMAX_INTERLACE_EN
    localparam int PAL_F2 = 313 * 16;   // 5008
    localparam int NTSC_F2 = 263 * 15;  // 3945
    localparam int ODD_F2 = 1;
`else
    localparam int PAL_F2 = 312 * 16;
    localparam int NTSC_F2 = 262 * 15;
    localparam int ODD_F2 = 0;
`endif

    savomax_sync_gen dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .enable_in       (enable_in),
        .format_sel_in   (format_sel_in),
        .hsync_out       (hsync_out),
        .vsync_out       (vsync_out),
        .csync_out       (csync_out),
        .field_start_out (field_start_out),
        .format_out      (format_out),
        .field_odd_out   (field_odd_out),
        .fsm_state_out   (fsm_state_out)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic do_reset();
        @(negedge clk_in);
        rst_n_in  = 1'b0;
        enable_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Wait for a 1->0 transition of vsync (which=0) or hsync (which=1),
    // sampled on falling clock edges; returns the cycle count at the fall.
    task automatic wait_fall(input int which, input int budget, output int at);
        logic prev;
        logic cur;
        bit   found;
        found = 1'b0;
        at    = -1;
        prev  = (which == 1) ? hsync_out : vsync_out;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk_in);
            cur = (which == 1) ? hsync_out : vsync_out;
            if (prev && !cur) begin
                found = 1'b1;
                at    = cyc;
            end
            prev = cur;
        end
        if (!found) check("fall_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int a, b, c, h1, t;

        // 1. reset state, PAL start latency and field period
        do_reset();
        check("rst_hsync", hsync_out, 1);
        check("rst_vsync", vsync_out, 1);
        check("rst_csync", csync_out, 1);
        check("rst_fstart", field_start_out, 0);
        check("rst_format", format_out, 0);
        check("rst_odd", field_odd_out, 0);
        check("rst_state", fsm_state_out, 0);

        format_sel_in = 1'b1;
        enable_in     = 1'b1;
        t = cyc;
        wait_fall(0, 20, a);
        check("t1_first_fall", a - t, 3);
        check("t1_fstart", field_start_out, 1);
        check("t1_format_pal", format_out, 3'b100);
        check("t1_hsync_low", hsync_out, 0);
        check("t1_csync_serr", csync_out, 1);
        check("t1_state_run", fsm_state_out, 2);
        @(negedge clk_in);
        check("t1_fstart_pulse", field_start_out, 0);
        check("t1_hsync_high", hsync_out, 1);
        check("t1_csync_inv", csync_out, 0);
        wait_fall(0, 6000, b);
        check("t1_pal_period", b - a, PAL_F1);

        // 2. NTSC period, hsync period and width
        do_reset();
        format_sel_in = 1'b0;
        enable_in     = 1'b1;
        wait_fall(0, 20, a);
        check("t2_format_ntsc", format_out, 3'b010);
        wait_fall(1, 40, h1);
        check("t2_hsync_period", h1 - a, 15);
        @(negedge clk_in);
        check("t2_hsync_width", hsync_out, 1);
        wait_fall(0, 5000, b);
        check("t2_ntsc_period", b - a, NTSC_F1);

        // 3. format change mid-field takes effect only at the boundary
        do_reset();
        format_sel_in = 1'b1;
        enable_in     = 1'b1;
        wait_fall(0, 20, a);
        repeat (100 * 16) @(negedge clk_in);
        format_sel_in = 1'b0;
        check("t3_format_held", format_out, 3'b100);
        wait_fall(0, 6000, b);
        check("t3_pal_kept", b - a, PAL_F1);
        check("t3_format_new", format_out, 3'b010);
        wait_fall(0, 5000, c);
        check("t3_ntsc_next", c - b, NTSC_F2);

        // 4. asynchronous reset in the middle of vsync
        do_reset();
        format_sel_in = 1'b1;
        enable_in     = 1'b1;
        wait_fall(0, 20, a);
        repeat (16) @(negedge clk_in);
        check("t4_pre_vsync", vsync_out, 0);
        check("t4_pre_hsync", hsync_out, 0);
        rst_n_in = 1'b0;
        #1;
        check("t4_async_hsync", hsync_out, 1);
        check("t4_async_vsync", vsync_out, 1);
        check("t4_async_csync", csync_out, 1);
        check("t4_async_format", format_out, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        t = cyc;
        wait_fall(0, 20, a);
        check("t4_restart_fall", a - t, 3);

        // 5. one-cycle enable drop at line 200, then a clean restart
        repeat (200 * 16 + 7) @(negedge clk_in);
        enable_in = 1'b0;
        @(negedge clk_in);
        check("t5_idle_state", fsm_state_out, 0);
        check("t5_idle_format", format_out, 0);
        check("t5_idle_vsync", vsync_out, 1);
        check("t5_idle_hsync", hsync_out, 1);
        check("t5_idle_csync", csync_out, 1);
        enable_in = 1'b1;
        t = cyc;
        wait_fall(0, 20, a);
        check("t5_reenable_fall", a - t, 3);
        check("t5_fstart", field_start_out, 1);
        wait_fall(0, 6000, b);
        check("t5_clean_field", b - a, PAL_F1);

        // 6. PAL field sequence (short/long alternation when interlaced)
        do_reset();
        format_sel_in = 1'b1;
        enable_in     = 1'b1;
        wait_fall(0, 20, a);
        check("t6_odd_first", field_odd_out, 0);
        wait_fall(0, 6000, b);
        check("t6_field1", b - a, PAL_F1);
        check("t6_odd_second", field_odd_out, ODD_F2);
        wait_fall(0, 6000, c);
        check("t6_field2", c - b, PAL_F2);
        check("t6_odd_third", field_odd_out, 0);
        check("t6_field2_pal", ((c - b) > 4500) ? 1 : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
